if_stage: RTL

- Instruction-fetch stage of the 5-stage pipeline; produces the IF/ID register (`Inst`, `PcPlus4`) consumed by the decode stage.
- Consumes decode's redirect and hazard outputs (`Branch`, `Jump`, `Stall`, `BranchOffset`, `JumpAddress`).
- Owns the PC, issues fetches to instruction memory over a req/ready + response-valid handshake, and buffers one returned word while decode stalls.
- Squashes wrong-path fetches on redirect, inserting NOP bubbles; there is no delay slot.

---
 rtl/if_stage.sv | 131 +++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready + response-valid
// handshake, buffers one word across decode stalls and squashes wrong-path fetches.
//
// state | meaning
// RUN   | normal fetch; requests may issue, responses feed IF/ID or the buffer
// DROP  | a wrong-path request is in flight; its response is discarded, no new requests
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        ResetN,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Stall,
    input  logic [31:0] BranchOffset,
    input  logic [25:0] JumpAddress,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic        IMemRespValid,
    input  logic [31:0] IMemRespData,
    output logic [31:0] Inst,
    output logic [31:0] PcPlus4
);

    typedef enum logic {RUN = 1'b0, DROP = 1'b1} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic        outstanding;
    logic        buf_full;
    logic [31:0] buf_word;
    logic [31:0] buf_addr;
    logic        accept;
    logic        redirect;
    logic        drop_needed;
    logic [31:0] target;

    assign IMemAddr    = pc;
    assign accept      = IMemReq && IMemReady;
    assign redirect    = Jump || (Branch && !Stall);
    // A redirect must wait out any request that will still answer after this edge.
    assign drop_needed = accept || (outstanding && !IMemRespValid);

    always_comb begin
        target = PcPlus4 + (BranchOffset << 2);
        if (Jump) begin
            target = {PcPlus4[31:28], JumpAddress, 2'b00};
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (redirect) begin
            state_next = drop_needed ? DROP : RUN;
        end else if (state == DROP && IMemRespValid) begin
            state_next = RUN;
        end
    end

    always_comb begin
        IMemReq = ResetN && (state == RUN) && !buf_full &&
                  (!outstanding || (IMemRespValid && !Stall));
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            pc          <= RESET_PC;
            req_pc      <= RESET_PC;
            outstanding <= 1'b0;
            buf_full    <= 1'b0;
            buf_word    <= NOP_INST;
            buf_addr    <= 32'h0;
            Inst        <= NOP_INST;
            PcPlus4     <= 32'h0;
        end else begin
            if (redirect) begin
                pc <= target;
            end else if (accept) begin
                pc <= pc + 32'd4;
            end

            if (accept) begin
                req_pc      <= pc;
                outstanding <= 1'b1;
            end else if (IMemRespValid) begin
                outstanding <= 1'b0;
            end

            if (redirect) begin
                buf_full <= 1'b0;
            end else if (state == RUN) begin
                if (Stall && IMemRespValid) begin
                    buf_full <= 1'b1;
                    buf_word <= IMemRespData;
                    buf_addr <= req_pc;
                end else if (!Stall && buf_full) begin
                    buf_full <= 1'b0;
                end
            end

            if (redirect) begin
                Inst <= NOP_INST;
            end else if (Stall) begin
                Inst <= Inst;
            end else if (state == DROP) begin
                Inst <= NOP_INST;
            end else if (buf_full) begin
                Inst    <= buf_word;
                PcPlus4 <= buf_addr + 32'd4;
            end else if (IMemRespValid) begin
                Inst    <= IMemRespData;
                PcPlus4 <= req_pc + 32'd4;
            end else begin
                Inst <= NOP_INST;
            end
        end
    end

endmodule
